// File: rtl/crc8_pkg.sv
// Shared CRC-8 (poly 0x07, MSB-first) definitions: polynomial, FSM states and
// the single-byte update used for odd trailing bytes.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_step16.sv
// Combinational 16-bit parallel CRC-8 update; [15] is shifted in first, so the
// result matches a byte update on [15:8] followed by one on [7:0].
module crc8_step16
  import crc8_pkg::*;
(
  input  logic [7:0]  crc_in,
  input  logic [15:0] data,
  output logic [7:0]  crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (crc_out[7] ^ data[i]) crc_out = {crc_out[6:0], 1'b0} ^ CRC8_POLY;
      else                      crc_out = {crc_out[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc8_stream_ctrl.sv
// Packet sequencer for CRC-8 over a 16-bit beat stream; emits final CRC, byte
// count and check-mode zero flag on a registered result handshake.
module crc8_stream_ctrl
  import crc8_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_init,
  input  logic [7:0]       cfg_xorout,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_last,
  input  logic             s_one,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_crc,
  output logic [LEN_W-1:0] m_len,
  output logic             m_zero
);

  state_t           state, state_nxt;
  logic [7:0]       crc_q, xorout_q;
  logic [7:0]       crc_base, xor_sel, step16_out, crc_nxt;
  logic [LEN_W-1:0] len_q, len_base, len_nxt;
  logic [LEN_W:0]   len_sum;
  logic             acc, first, tail;

  assign acc   = s_valid && s_ready;
  assign first = (state == IDLE);
  // s_one only counts on the last beat; otherwise the beat is a full 16-bit one
  assign tail  = s_last && s_one;

  assign crc_base = first ? cfg_init   : crc_q;
  assign xor_sel  = first ? cfg_xorout : xorout_q;

  crc8_step16 u_step16 (
    .crc_in  (crc_base),
    .data    (s_data),
    .crc_out (step16_out)
  );

  assign crc_nxt  = tail ? crc8_byte(crc_base, s_data[15:8]) : step16_out;

  assign len_base = first ? '0 : len_q;
  assign len_sum  = {1'b0, len_base} + (tail ? (LEN_W+1)'(1) : (LEN_W+1)'(2));
  assign len_nxt  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    case (state)
      IDLE, RUN: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = s_last ? DONE : RUN;
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      crc_q    <= 8'h00;
      xorout_q <= 8'h00;
      len_q    <= '0;
      m_crc    <= 8'h00;
      m_len    <= '0;
      m_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        crc_q <= crc_nxt;
        len_q <= len_nxt;
        if (first) xorout_q <= cfg_xorout;
        if (s_last) begin
          m_crc  <= crc_nxt ^ xor_sel;
          m_len  <= len_nxt;
          m_zero <= (crc_nxt == 8'h00);
        end
      end
    end
  end

endmodule

// File: doc/crc8_stream_ctrl.md
# crc8_stream_ctrl

Packet-level sequencer for a CRC-8 update datapath on the NACK generator's 16-bit byte stream. The block accepts packets as 16-bit beats over a valid/ready handshake and seeds the CRC register per packet. It runs one 16-bit CRC step per accepted beat and one 8-bit step for an odd trailing byte. It then presents the final CRC and byte count on a result handshake for the NACK framer.

## Interface
- `LEN_W`, default 16: width of the byte-count output; the count saturates at all-ones.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_init` in 8: CRC seed, sampled on the first beat of each packet.
- `cfg_xorout` in 8: final XOR mask, sampled on the first beat of each packet.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: block can accept a beat.
- `s_data` in 16: beat data; the first byte on the wire is `[15:8]`, the second is `[7:0]`.
- `s_last` in 1: last beat of the packet.
- `s_one` in 1: qualified by `s_last`; only `[15:8]` is valid and `[7:0]` is ignored.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result consumer ready.
- `m_crc` out 8: final CRC, equal to register XOR the sampled `cfg_xorout`.
- `m_len` out LEN_W: number of bytes in the packet.
- `m_zero` out 1: register equals 0x00 before the xorout is applied (check-mode pass indicator).

## Operation
- CRC definition: polynomial x^8+x^2+x+1 (0x07), non-reflected, MSB-first.
- Bit order per beat: bit `[15]` is processed first, then down to bit 0; on an `s_one` beat, down to bit 8.
- FSM states:
  - IDLE: `s_ready`=1. An accepted beat loads the CRC from `cfg_init`, latches `cfg_xorout`, and applies the step.
    - If `s_last` is set, go to DONE; otherwise go to RUN.
  - RUN: `s_ready`=1. Each accepted beat updates the CRC; `s_last` moves the FSM to DONE.
  - DONE: `s_ready`=0, `m_valid`=1. When `m_valid && m_ready`, go to IDLE.
- Step selection: a 16-bit step for a full beat; an 8-bit step on `[15:8]` when `s_last && s_one`.
- `s_one` without `s_last` is a protocol error; the beat is treated as a full 16-bit beat.
- Byte count:
  - +2 per full beat, +1 for an `s_one` last beat.
  - Saturates at 2^LEN_W−1.
  - Reloaded on the first beat of each packet.
- `m_crc`, `m_len` and `m_zero` are registered and hold stable while `m_valid`=1 and `m_ready`=0.
- A beat with `s_valid`=0 has no effect; there is no timeout.

## Timing
- Reset values: FSM=IDLE, `s_ready`=1, `m_valid`=0, `m_crc`=0x00, `m_len`=0, `m_zero`=0, CRC register=0x00.
- Reset asserted mid-packet discards the packet. After release the block is in IDLE, and the next beat is treated as a first beat.
- Throughput: one beat per cycle in IDLE/RUN, with no stall cycles inside a packet.
- Latency: `m_valid` rises on the cycle after the last beat is accepted.
- Inter-packet gap: the result handshake cycle and the next packet's first beat cannot overlap because `s_ready`=0 in DONE. A back-to-back stream with `m_ready` held at 1 therefore sees exactly one bubble cycle per packet.
- `s_ready` is a function of registered state only; there is no combinational path from `m_ready` to `s_ready`.
- `m_valid` never drops without a handshake.
- Config changes mid-packet have no effect until the next first beat.

## Structure
- Package `crc8_pkg` holds:
  - `CRC8_POLY` = 8'h07.
  - The FSM state enum `{IDLE, RUN, DONE}`.
  - Function `crc8_byte(crc, byte)`, used for the odd-tail step.
- Sub-module `crc8_step16`: purely combinational 16-bit parallel update (crc_in[7:0], data[15:0] → crc_out[7:0]), built for the 0x07 polynomial.
  - It must equal two chained `crc8_byte` calls, `[15:8]` then `[7:0]`.
  - It is instantiated once in the controller.

## Test plan
- "123456789" as beats 0x3132, 0x3334, 0x3536, 0x3738, then 0x39xx with `s_last`=1 and `s_one`=1; init=0x00, xorout=0x00 → `m_crc`=0xF4, `m_len`=9, `m_zero`=0.
- Single beat 0x01xx with `s_last`=1 and `s_one`=1; init=0x00 → `m_crc`=0x07, `m_len`=1. Repeat with xorout=0x55 → `m_crc`=0x52.
- Check mode: beats 0x3132, 0x3334, 0x3536, 0x3738, 0x39F4 with the last beat full; init=0x00 → `m_zero`=1, `m_len`=10.
- Backpressure: hold `m_ready`=0 for 5 cycles after a result.
  - `s_ready` stays 0 and `m_crc`/`m_len` stay stable.
  - On release, the handshake completes and the next packet's first beat is accepted the following cycle.
- Reset mid-packet: assert `rst` after 2 beats of packet A, then send "123456789" → 0xF4, showing no residue from packet A.
- Random packets of 1–64 bytes with random `s_valid`/`m_ready` gaps and random seed/xorout, scoreboarded against a bitwise 0x07 reference model.
